// File: rtl/round_robin_multiplexor.sv
// Registered N:1 round-robin multiplexor. Merges N valid/ready source
// channels onto one output channel and tags each word with its source
// address so a downstream demultiplexor can route it back out.
module round_robin_multiplexor #(
  parameter int ADDRESS_WIDTH = 2,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [(2**ADDRESS_WIDTH)-1:0]         i_valid,
  input  logic [(2**ADDRESS_WIDTH)*DATA_WIDTH-1:0] i_data,
  output logic [(2**ADDRESS_WIDTH)-1:0]         o_ready,
  output logic                                  o_valid,
  output logic [DATA_WIDTH-1:0]                 o_data,
  output logic [ADDRESS_WIDTH-1:0]              o_add,
  input  logic                                  i_ready
);

  localparam int N = 2 ** ADDRESS_WIDTH;

  logic                     vld_p0;
  logic [DATA_WIDTH-1:0]    data_p0;
  logic [ADDRESS_WIDTH-1:0] add_p0;
  logic [ADDRESS_WIDTH-1:0] last_p0;

  logic                     load;
  logic                     found;
  logic [ADDRESS_WIDTH-1:0] grant;
  logic [ADDRESS_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0]    sel_data;

  // Output register can take a new word when empty or being drained now.
  assign load = ~vld_p0 | i_ready;

  // Round-robin search starting just after the last granted channel;
  // the address arithmetic wraps naturally at N.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = last_p0 + i[ADDRESS_WIDTH-1:0];
      if (!found && i_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign sel_data = i_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];

  // Ready is one-hot on the granted channel, and suppressed during reset.
  always_comb begin
    o_ready = '0;
    if (load && found && !i_rst) begin
      o_ready[grant] = 1'b1;
    end
  end

  // Stage p0: output register and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      add_p0  <= '0;
      last_p0 <= '1;
    end else if (load) begin
      if (found) begin
        vld_p0  <= 1'b1;
        data_p0 <= sel_data;
        add_p0  <= grant;
        last_p0 <= grant;
      end else begin
        vld_p0  <= 1'b0;
      end
    end
  end

  assign o_valid = vld_p0;
  assign o_data  = data_p0;
  assign o_add   = add_p0;

endmodule

// File: tb/tb_round_robin_multiplexor.sv
// Scoreboard bench for round_robin_multiplexor (ADDRESS_WIDTH=2, DATA_WIDTH=8).
module tb_round_robin_multiplexor;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_valid;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]    o_ready;
  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic [AW-1:0]   o_add;
  logic            i_ready;

  int tests = 0;
  int fails = 0;
  logic [AW+DW-1:0] exp_q[$];

  round_robin_multiplexor #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(i_valid),
    .i_data (i_data),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_data (o_data),
    .o_add  (o_add),
    .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && o_valid === 1'b1 && i_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got add=%0d data=%h, expected none", o_add, o_data);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        chk("xfer_word", {22'd0, o_add, o_data}, {22'd0, e});
      end
    end
  end

  initial begin
    logic [1:0] ch;
    rst     = 1'b1;
    i_valid = '0;
    i_ready = 1'b0;
    i_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    cyc();
    @(negedge clk);
    chk("ready_in_reset", {28'd0, o_ready}, 32'd0);
    cyc();
    rst     = 1'b0;
    i_ready = 1'b1;

    // Idle: nothing valid for five cycles.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_state", {17'd0, o_valid, o_data, o_add, o_ready}, 32'd0);
      cyc();
    end

    // Single source on channel 1.
    i_data  = {8'h13, 8'h12, 8'hA5, 8'h10};
    i_valid = 4'b0010;
    @(negedge clk);
    chk("single_ready", {28'd0, o_ready}, 32'h2);
    exp_q.push_back({2'd1, 8'hA5});
    cyc();
    i_valid = '0;
    @(negedge clk);
    chk("single_out", {21'd0, o_valid, o_data, o_add}, {21'd0, 1'b1, 8'hA5, 2'd1});
    cyc();
    i_data = {8'h13, 8'h12, 8'h11, 8'h10};

    // Reset to restore the pointer, then all channels valid.
    rst = 1'b1;
    cyc();
    rst     = 1'b0;
    i_valid = 4'b1111;
    for (int k = 0; k < 11; k++) begin
      ch = 2'(k % 4);
      @(negedge clk);
      chk("rr_ready", {28'd0, o_ready}, 32'd1 << ch);
      if (k > 0) chk("rr_valid", {31'd0, o_valid}, 32'd1);
      exp_q.push_back({ch, 8'h10 + 8'(ch)});
      cyc();
    end

    // Backpressure with channel 2's word held.
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready", {28'd0, o_ready}, 32'd0);
      chk("bp_hold", {21'd0, o_valid, o_data, o_add}, {21'd0, 1'b1, 8'h12, 2'd2});
      cyc();
    end
    i_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {28'd0, o_ready}, 32'h8);
    exp_q.push_back({2'd3, 8'h13});
    cyc();

    // Wrap and skip: channels 0 and 2 only.
    i_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      ch = (k == 1) ? 2'd2 : 2'd0;
      @(negedge clk);
      chk("skip_ready", {28'd0, o_ready}, 32'd1 << ch);
      exp_q.push_back({ch, 8'h10 + 8'(ch)});
      cyc();
    end

    // Load channel 2 (not scored: it is discarded by reset).
    i_valid = 4'b0100;
    @(negedge clk);
    chk("pre_rst_ready", {28'd0, o_ready}, 32'h4);
    cyc();
    rst     = 1'b1;
    i_valid = 4'b1111;
    @(negedge clk);
    chk("pre_rst_word", {21'd0, o_valid, o_data, o_add}, {21'd0, 1'b1, 8'h12, 2'd2});
    chk("mid_rst_ready", {28'd0, o_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("post_rst_ready", {28'd0, o_ready}, 32'h1);
    exp_q.push_back({2'd0, 8'h10});
    cyc();
    i_valid = '0;
    cyc();
    cyc();
    @(negedge clk);
    chk("drained", {31'd0, o_valid}, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
